// File: rtl/fifo_rd_packer_pkg.sv
// Shared defaults for the byte-wide async FIFO and its read-side packer.
package fifo_rd_packer_pkg;
    localparam int FIFO_W_DEFAULT = 8;
    localparam int PACK_N_DEFAULT = 4;
endpackage

// File: rtl/fifo_rd_packer.sv
// Read-domain consumer: pops FIFO entries, packs N of them per output word,
// and emits a keep-masked partial word on flush.
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int W = FIFO_W_DEFAULT,
    parameter int N = PACK_N_DEFAULT
) (
    input  logic           rd_clk,
    input  logic           rd_reset_n,
    input  logic           fifo_empty,
    output logic           fifo_rd_en,
    input  logic [W-1:0]   fifo_rd_data,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data,
    output logic [N-1:0]   out_keep,
    output logic           out_last
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(N);

    logic [N*W-1:0] asm_q;
    logic [CW-1:0]  cnt;
    logic           pend;
    logic           flush_req;
    logic [CW:0]    inflight;
    logic           out_free;
    logic           flush_ready;
    logic           do_word;
    logic           do_flush_emit;
    logic           do_flush_drop;

    function automatic logic [N-1:0] keep_mask(input logic [CW-1:0] c);
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) begin
            m[i] = (CW'(i) < c);
        end
        return m;
    endfunction

    function automatic logic [N*W-1:0] data_mask(input logic [N-1:0] k);
        logic [N*W-1:0] m;
        for (int i = 0; i < N; i++) begin
            m[i*W +: W] = {W{k[i]}};
        end
        return m;
    endfunction

    // Entries already captured plus the one in flight must leave room in asm.
    assign inflight      = {1'b0, cnt} + {{CW{1'b0}}, pend};
    assign fifo_rd_en    = rd_reset_n & ~fifo_empty & ~flush_req & (inflight < {1'b0, CNT_FULL});
    assign out_free      = ~out_valid | out_ready;
    assign do_word       = (cnt == CNT_FULL) & out_free;
    assign flush_ready   = flush_req & ~pend;
    assign do_flush_emit = flush_ready & (cnt != '0) & (cnt != CNT_FULL) & out_free;
    assign do_flush_drop = flush_ready & (cnt == '0);

    // Control and output register
    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
            cnt       <= '0;
            pend      <= 1'b0;
            flush_req <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else begin
            pend      <= fifo_rd_en;
            flush_req <= flush | (flush_req & ~(do_flush_emit | do_flush_drop));

            if (pend) begin
                cnt <= cnt + CW'(1);
            end else if (do_word | do_flush_emit) begin
                cnt <= '0;
            end

            if (do_word) begin
                out_data  <= asm_q;
                out_keep  <= '1;
                out_last  <= 1'b0;
                out_valid <= 1'b1;
            end else if (do_flush_emit) begin
                out_data  <= asm_q & data_mask(keep_mask(cnt));
                out_keep  <= keep_mask(cnt);
                out_last  <= 1'b1;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Assembly register: data only, slots beyond cnt are masked on flush
    always_ff @(posedge rd_clk) begin
        if (pend) begin
            for (int i = 0; i < N; i++) begin
                if (cnt == CW'(i)) begin
                    asm_q[i*W +: W] <= fifo_rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO model on the read port, scoreboard on the output stream.
module tb_fifo_rd_packer;

    localparam int W = 8;
    localparam int N = 4;

    typedef struct packed {
        logic [N*W-1:0] data;
        logic [N-1:0]   keep;
        logic           last;
    } exp_t;

    logic           rd_clk = 1'b0;
    logic           rd_reset_n;
    logic           fifo_empty;
    logic           fifo_rd_en;
    logic [W-1:0]   fifo_rd_data = '0;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_keep;
    logic           out_last;

    logic [7:0] mem [0:255];
    int wr_ptr     = 0;
    int rd_ptr     = 0;
    int pop_count  = 0;
    int empty_pops = 0;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    fifo_rd_packer #(.W(W), .N(N)) dut (
        .rd_clk       (rd_clk),
        .rd_reset_n   (rd_reset_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_keep     (out_keep),
        .out_last     (out_last)
    );

    always #5 rd_clk = ~rd_clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    // Read port of the FIFO: data appears one cycle after the pop
    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            if (rd_ptr == wr_ptr) begin
                empty_pops <= empty_pops + 1;
            end else begin
                fifo_rd_data <= mem[rd_ptr[7:0]];
                rd_ptr       <= rd_ptr + 1;
                pop_count    <= pop_count + 1;
            end
        end
    end

    // Scoreboard: every accepted word must match the oldest expectation
    always @(negedge rd_clk) begin
        if (rd_reset_n && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_word: got data=%h keep=%h last=%b, required no word",
                         out_data, out_keep, out_last);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_data !== e.data || out_keep !== e.keep || out_last !== e.last)
                    $display("FAIL word: got data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                             out_data, out_keep, out_last, e.data, e.keep, e.last);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_word(input logic [N*W-1:0] d, input logic [N-1:0] k, input logic l);
        exp_t e;
        e.data = d;
        e.keep = k;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rd_reset_n = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        tick();
        tick();
        for (int i = 1; i <= 4; i++) push_byte(8'(i));
        repeat (5) tick();
        n_checks++;
        if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b, required 0", fifo_rd_en);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        else n_pass++;
        n_checks++;
        if (out_data !== '0) $display("FAIL reset_out_data: got %h, required 0", out_data);
        else n_pass++;
        n_checks++;
        if (out_keep !== '0) $display("FAIL reset_out_keep: got %h, required 0", out_keep);
        else n_pass++;
        n_checks++;
        if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b, required 0", out_last);
        else n_pass++;
        n_checks++;
        if (pop_count !== 0) $display("FAIL reset_pops: got %0d, required 0", pop_count);
        else n_pass++;
    endtask

    task automatic test_streaming();
        bit ok;
        expect_word(32'h04030201, 4'hF, 1'b0);
        expect_word(32'h08070605, 4'hF, 1'b0);
        for (int i = 5; i <= 8; i++) push_byte(8'(i));
        rd_reset_n = 1'b1;
        wait_drain(40, ok);
        n_checks++;
        if (!ok) $display("FAIL stream_drain: pending words %0d, required 0", exp_q.size());
        else n_pass++;
        tick();
        n_checks++;
        if (fifo_rd_en !== 1'b0) $display("FAIL stream_rd_en_idle: got %b, required 0", fifo_rd_en);
        else n_pass++;
        n_checks++;
        if (pop_count !== 8) $display("FAIL stream_pops: got %0d, required 8", pop_count);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        int base;
        int hold_err;
        logic [N*W-1:0] held;
        bit seen;
        base      = pop_count;
        hold_err  = 0;
        seen      = 1'b0;
        held      = '0;
        out_ready = 1'b0;
        expect_word(32'h04030201, 4'hF, 1'b0);
        expect_word(32'h08070605, 4'hF, 1'b0);
        expect_word(32'h0C0B0A09, 4'hF, 1'b0);
        for (int i = 1; i <= 12; i++) push_byte(8'(i));
        for (int i = 0; i < 30; i++) begin
            tick();
            if (seen) begin
                if (!out_valid || out_data !== held) hold_err++;
            end else if (out_valid) begin
                seen = 1'b1;
                held = out_data;
            end
        end
        n_checks++;
        if (pop_count - base !== 8) $display("FAIL bp_pops: got %0d, required 8", pop_count - base);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h04030201)
            $display("FAIL bp_held_word: got valid=%b data=%h, required valid=1 data=04030201",
                     out_valid, out_data);
        else n_pass++;
        n_checks++;
        if (hold_err !== 0) $display("FAIL bp_stable: got %0d unstable cycles, required 0", hold_err);
        else n_pass++;
        n_checks++;
        if (fifo_rd_en !== 1'b0) $display("FAIL bp_rd_en: got %b, required 0", fifo_rd_en);
        else n_pass++;
        out_ready = 1'b1;
        wait_drain(60, ok);
        n_checks++;
        if (!ok) $display("FAIL bp_drain: pending words %0d, required 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (pop_count - base !== 12) $display("FAIL bp_total_pops: got %0d, required 12", pop_count - base);
        else n_pass++;
    endtask

    task automatic test_partial_flush();
        bit ok;
        push_byte(8'hA1);
        push_byte(8'hA2);
        push_byte(8'hA3);
        repeat (8) tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL pflush_no_early_word: got %b, required 0", out_valid);
        else n_pass++;
        expect_word(32'h00A3A2A1, 4'h7, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_drain(20, ok);
        n_checks++;
        if (!ok) $display("FAIL pflush_drain: pending words %0d, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_flush_empty();
        bit ok;
        int spurious;
        spurious = 0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) spurious++;
        end
        n_checks++;
        if (spurious !== 0) $display("FAIL eflush_no_word: got %0d valid cycles, required 0", spurious);
        else n_pass++;
        expect_word(32'h14131211, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) push_byte(8'(8'h11 + i));
        wait_drain(30, ok);
        n_checks++;
        if (!ok) $display("FAIL eflush_resume: pending words %0d, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_flush_with_pop();
        bit ok;
        bit armed;
        int base;
        base  = pop_count;
        armed = 1'b0;
        expect_word(32'h00B3B2B1, 4'h7, 1'b1);
        push_byte(8'hB1);
        push_byte(8'hB2);
        push_byte(8'hB3);
        for (int i = 0; i < 10 && !armed; i++) begin
            tick();
            if (pop_count == base + 2 && fifo_rd_en) begin
                flush = 1'b1;
                armed = 1'b1;
                tick();
                flush = 1'b0;
            end
        end
        n_checks++;
        if (!armed) $display("FAIL pflush_pop_align: got no third pop, required one");
        else n_pass++;
        wait_drain(20, ok);
        n_checks++;
        if (!ok) $display("FAIL pflush_pop_drain: pending words %0d, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_word();
        bit ok;
        push_byte(8'hC1);
        push_byte(8'hC2);
        repeat (6) tick();
        rd_reset_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || fifo_rd_en !== 1'b0)
            $display("FAIL midreset_outputs: got valid=%b rd_en=%b, required 0 0", out_valid, fifo_rd_en);
        else n_pass++;
        rd_reset_n = 1'b1;
        expect_word(32'hD4D3D2D1, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) push_byte(8'(8'hD1 + i));
        wait_drain(30, ok);
        n_checks++;
        if (!ok) $display("FAIL midreset_drain: pending words %0d, required 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        rd_reset_n = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_partial_flush();
        test_flush_empty();
        test_flush_with_pop();
        test_reset_mid_word();
        repeat (3) tick();
        n_checks++;
        if (empty_pops !== 0) $display("FAIL empty_pop: got %0d pops of empty FIFO, required 0", empty_pops);
        else n_pass++;
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL leftover_words: got %0d, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the byte-wide `async_fifo`, clocked in the FIFO read domain. It pops `W`-bit entries through the FIFO's `rd_en`/`empty`/`rd_data` port and packs `N` consecutive entries into one `N*W`-bit word. Each word is presented on a valid/ready stream to the downstream datapath. A `flush` request emits a partial word with a byte-keep mask, so a stream tail never strands in the packer.

## Interface

Parameters:
- `W`, 8: FIFO entry width; must equal the `W` of the `async_fifo` it drains.
- `N`, 4: entries per output word; N ≥ 2.

Ports:
- `rd_clk`  in  1  read-domain clock, shared with the FIFO read side.
- `rd_reset_n`  in  1  reset, asynchronous assert, active-low.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_rd_en`  out  1  pop strobe to FIFO `rd_en`.
- `fifo_rd_data`  in  W  FIFO `rd_data`; valid one cycle after a pop.
- `flush`  in  1  single-cycle request to emit the partial word.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  N*W  packed word; first popped entry sits in `[W-1:0]`.
- `out_keep`  out  N  per-entry valid mask; bit i covers `out_data[i*W +: W]`.
- `out_last`  out  1  set only on flush-terminated words.

## Operation

- Internal state: assembly register `asm` (N*W), count `cnt` (0..N), `pend` (a pop is in flight), `flush_req`, and output register {`out_data`, `out_keep`, `out_last`, `out_valid`}.
- Pop rule: `fifo_rd_en = rd_reset_n & ~fifo_empty & ~flush_req & (cnt + pend < N)`.
  - Combinational from registered state plus `fifo_empty`.
  - Never pops an empty FIFO.
- Capture: if `pend` is 1, `fifo_rd_data` is written into `asm[cnt*W +: W]` and `cnt` increments. `pend` takes the value of `fifo_rd_en` each cycle.
- Word transfer: when `cnt == N` and the output register is free, the output register loads `asm` with `keep = all ones` and `last = 0`. `cnt` then returns to 0.
  - The output register is free when `~out_valid | out_ready`.
- Flush:
  - A `flush` pulse sets `flush_req`, which blocks new pops.
  - Once `pend == 0`, one of two things happens:
    - If `0 < cnt < N` and the output register is free: load `asm` with the unused entries zeroed, `keep = (1<<cnt)-1`, `last = 1`. Then `cnt = 0` and `flush_req` clears.
    - If `cnt == 0`: `flush_req` clears with no output.
  - If `cnt == N`, the normal transfer runs first and the flush then resolves with `cnt == 0`.
- A `flush` that arrives while `flush_req` is already set is absorbed.
- `flush` and a capture in the same cycle: the capture is kept and counted.

## Timing

- Reset values: `out_valid` 0, `out_data` 0, `out_keep` 0, `out_last` 0, `fifo_rd_en` 0. Internally `cnt` 0, `pend` 0, `flush_req` 0.
- Reset mid-operation drops any in-flight byte, partial word and pending output. The FIFO's own reset governs its contents.
- Pop-to-capture latency is 1 cycle. Capture-of-Nth-entry to `out_valid` is 1 cycle when the output register is free.
- Handshake:
  - A word transfers on `out_valid & out_ready`.
  - While `out_valid & ~out_ready`, `out_data`, `out_keep` and `out_last` are held stable.
  - `out_valid` never drops without a transfer.
- Backpressure bound: with `out_ready` low, the packer holds at most 2N entries (output register plus full `asm`), then pops stop.
- Throughput with `out_ready` high and a non-empty FIFO: one word per N+2 cycles, in order, no loss or duplication.
- `fifo_empty` rising during `pend` does not affect the in-flight capture.

## Structure

- The shared FIFO package holds `FIFO_W_DEFAULT = 8` and `PACK_N_DEFAULT = 4`. `async_fifo` and this block both take their defaults from it.
- Single module; no sub-module is warranted. Keep the output register inline.

## Test plan

- Reset: hold `rd_reset_n` low with a non-empty FIFO → `fifo_rd_en` 0, `out_valid`/`out_data`/`out_keep`/`out_last` all 0.
- Streaming: FIFO holds 0x01..0x08, N=4, `out_ready` 1 → words 0x04030201 then 0x08070605, each with keep 0xF and last 0. `fifo_rd_en` is low once the FIFO is empty.
- Backpressure: 12 entries queued, `out_ready` 0 → exactly 8 pops, `out_data` stays at 0x04030201. Releasing `out_ready` → 0x08070605 then 0x0C0B0A09.
- Partial flush: 0xA1, 0xA2, 0xA3, then FIFO empty, pulse `flush` → `out_data` 0x00A3A2A1, keep 0x7, last 1.
- Flush edge cases:
  - `flush` with `cnt` 0 and no pop in flight → no output.
  - `flush` in the same cycle as the pop of a third entry → waits for the capture, then emits keep 0x7.
- Reset mid-word: 2 entries captured, pulse `rd_reset_n` low → after reset, the next 4 fresh entries form one full word with no stale bytes.
